// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//   One pipeline register slot between two processor stages. It carries a
//   valid bit, the PC, an opaque payload (instruction/operands/immediate) and
//   the Tnew hazard field, and keeps a count of how long a real instruction
//   has been held by a stall.
//
//   Per-edge priority: flush > hold (en=0) > load (en=1).
//
// Ports
//   clk        in   sole clock, rising edge
//   reset      in   asynchronous, active-high reset
//   en         in   load enable; 0 = stall (hold current contents)
//   flush      in   insert a bubble; overrides en
//   valid_in   in   upstream slot holds a real instruction
//   pc_in      in   upstream PC (32)
//   data_in    in   upstream payload (DATA_W)
//   tnew_in    in   upstream Tnew (TNEW_W)
//   valid_out  out  registered valid
//   pc_out     out  registered PC
//   data_out   out  registered payload
//   tnew_out   out  registered Tnew
//   stall_cnt  out  consecutive cycles a valid instruction has been held
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
   parameter int unsigned DATA_W   = 128,
   parameter int unsigned TNEW_W   = 2,
   parameter int unsigned CNT_W    = 8,
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter int unsigned KEEP_PC  = 1,
   parameter int unsigned DEC_TNEW = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              flush,
   input  logic              valid_in,
   input  logic [31:0]       pc_in,
   input  logic [DATA_W-1:0] data_in,
   input  logic [TNEW_W-1:0] tnew_in,
   output logic              valid_out,
   output logic [31:0]       pc_out,
   output logic [DATA_W-1:0] data_out,
   output logic [TNEW_W-1:0] tnew_out,
   output logic [CNT_W-1:0]  stall_cnt
);

   logic              valid_q, valid_d;
   logic [31:0]       pc_q,    pc_d;
   logic [DATA_W-1:0] data_q,  data_d;
   logic [TNEW_W-1:0] tnew_q,  tnew_d;
   logic [CNT_W-1:0]  cnt_q,   cnt_d;

   logic [TNEW_W-1:0] tnew_dec;
   logic              cnt_sat;

   // Tnew ages by one stage when it crosses this register; it never wraps
   // below zero because a result that is already available stays available.
   always_comb begin
      tnew_dec = tnew_in;
      if (DEC_TNEW != 0) begin
         if (tnew_in != '0) tnew_dec = tnew_in - TNEW_W'(1);
         else               tnew_dec = '0;
      end
   end

   assign cnt_sat = (cnt_q == {CNT_W{1'b1}});

   always_comb begin
      valid_d = valid_q;
      pc_d    = pc_q;
      data_d  = data_q;
      tnew_d  = tnew_q;
      cnt_d   = cnt_q;

      if (flush) begin
         // A bubble still tracks the PC so an exception taken here can
         // report a meaningful EPC.
         valid_d = 1'b0;
         pc_d    = (KEEP_PC != 0) ? pc_in : 32'h0;
         data_d  = '0;
         tnew_d  = '0;
         cnt_d   = '0;
      end else if (!en) begin
         // Hold: only the stall counter moves, and only for a real
         // instruction; an empty slot never accumulates stall time.
         if (valid_q) begin
            if (!cnt_sat) cnt_d = cnt_q + CNT_W'(1);
         end else begin
            cnt_d = '0;
         end
      end else begin
         valid_d = valid_in;
         pc_d    = pc_in;
         cnt_d   = '0;
         if (valid_in) begin
            data_d = data_in;
            tnew_d = tnew_dec;
         end else begin
            // An empty slot carries no payload or hazard information.
            data_d = '0;
            tnew_d = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= 1'b0;
         pc_q    <= RESET_PC;
         data_q  <= '0;
         tnew_q  <= '0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         pc_q    <= pc_d;
         data_q  <= data_d;
         tnew_q  <= tnew_d;
         cnt_q   <= cnt_d;
      end
   end

   assign valid_out = valid_q;
   assign pc_out    = pc_q;
   assign data_out  = data_q;
   assign tnew_out  = tnew_q;
   assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//   Two instances share one stimulus stream: dut_a with default parameters,
//   dut_b with KEEP_PC=0 and DEC_TNEW=0. Each task pushes the expected result
//   of every step into per-instance queues, then pops and compares once the
//   DUT has produced that result.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

   typedef struct packed {
      logic         v;
      logic [31:0]  pc;
      logic [127:0] d;
      logic [1:0]   t;
      logic [7:0]   c;
   } obs_t;

   localparam logic [31:0]  RPC = 32'h0000_3000;
   localparam logic [127:0] A5  = {16{8'hA5}};

   logic         clk = 1'b0;
   logic         reset;
   logic         en, flush, valid_in;
   logic [31:0]  pc_in;
   logic [127:0] data_in;
   logic [1:0]   tnew_in;

   logic         va, vb;
   logic [31:0]  pca, pcb;
   logic [127:0] da, db;
   logic [1:0]   ta, tb;
   logic [7:0]   ca, cb;

   int passed = 0;
   int total  = 0;

   obs_t qa[$];
   obs_t qb[$];

   always #5 clk = ~clk;

   pipe_stage_reg dut_a (
      .clk(clk), .reset(reset), .en(en), .flush(flush), .valid_in(valid_in),
      .pc_in(pc_in), .data_in(data_in), .tnew_in(tnew_in),
      .valid_out(va), .pc_out(pca), .data_out(da), .tnew_out(ta), .stall_cnt(ca)
   );

   pipe_stage_reg #(.KEEP_PC(0), .DEC_TNEW(0)) dut_b (
      .clk(clk), .reset(reset), .en(en), .flush(flush), .valid_in(valid_in),
      .pc_in(pc_in), .data_in(data_in), .tnew_in(tnew_in),
      .valid_out(vb), .pc_out(pcb), .data_out(db), .tnew_out(tb), .stall_cnt(cb)
   );

   function automatic obs_t mk(logic v, logic [31:0] p, logic [127:0] d,
                               logic [1:0] t, logic [7:0] c);
      obs_t o;
      o.v = v; o.pc = p; o.d = d; o.t = t; o.c = c;
      return o;
   endfunction

   function automatic obs_t obs_a();
      return mk(va, pca, da, ta, ca);
   endfunction

   function automatic obs_t obs_b();
      return mk(vb, pcb, db, tb, cb);
   endfunction

   function automatic string fmt(obs_t o);
      return $sformatf("v=%b pc=%h d=%h t=%0d c=%0d", o.v, o.pc, o.d, o.t, o.c);
   endfunction

   function automatic logic [1:0] dec2(logic [1:0] t);
      return (t == 2'd0) ? 2'd0 : t - 2'd1;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic drive(input logic e, input logic f, input logic v,
                        input logic [31:0] p, input logic [127:0] d,
                        input logic [1:0] t);
      en = e; flush = f; valid_in = v; pc_in = p; data_in = d; tnew_in = t;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reset held across an edge, first load after release, then an
   // asynchronous reset pulse between edges.
   task automatic test_reset();
      obs_t ea, eb, oa, ob;
      logic [127:0] d0;
      d0 = rnd128();
      for (int s = 0; s < 4; s++) begin
         case (s)
            0: begin
               drive(1, 0, 1, 32'h3100, d0, 2'd2);
               qa.push_back(mk(0, RPC, '0, 0, 0));
               qb.push_back(mk(0, RPC, '0, 0, 0));
               tick();
            end
            1: begin
               reset = 1'b0;
               qa.push_back(mk(1, 32'h3100, d0, 2'd1, 0));
               qb.push_back(mk(1, 32'h3100, d0, 2'd2, 0));
               tick();
            end
            2: begin
               #3 reset = 1'b1;
               qa.push_back(mk(0, RPC, '0, 0, 0));
               qb.push_back(mk(0, RPC, '0, 0, 0));
               #1;
            end
            default: begin
               reset = 1'b0;
               qa.push_back(mk(1, 32'h3100, d0, 2'd1, 0));
               qb.push_back(mk(1, 32'h3100, d0, 2'd2, 0));
               tick();
            end
         endcase
         ea = qa.pop_front(); eb = qb.pop_front(); oa = obs_a(); ob = obs_b();
         total += 2;
         if (oa !== ea) $display("FAIL reset[%0d] A got %s exp %s", s, fmt(oa), fmt(ea));
         else passed++;
         if (ob !== eb) $display("FAIL reset[%0d] B got %s exp %s", s, fmt(ob), fmt(eb));
         else passed++;
      end
   endtask

   task automatic test_load();
      obs_t ea, eb, oa, ob;
      logic [1:0]   tn [4] = '{2'd2, 2'd0, 2'd3, 2'd1};
      logic [127:0] d;
      logic [31:0]  p;
      for (int i = 0; i < 4; i++) begin
         d = (i == 0) ? A5 : rnd128();
         p = 32'h3004 + 32'(i * 4);
         drive(1, 0, 1, p, d, tn[i]);
         qa.push_back(mk(1, p, d, dec2(tn[i]), 0));
         qb.push_back(mk(1, p, d, tn[i], 0));
         tick();
         ea = qa.pop_front(); eb = qb.pop_front(); oa = obs_a(); ob = obs_b();
         total += 2;
         if (oa !== ea) $display("FAIL load[%0d] A got %s exp %s", i, fmt(oa), fmt(ea));
         else passed++;
         if (ob !== eb) $display("FAIL load[%0d] B got %s exp %s", i, fmt(ob), fmt(eb));
         else passed++;
      end
   endtask

   // 300-cycle stall with the inputs churning: contents frozen, counter
   // saturates at 255, then one load clears it.
   task automatic test_stall();
      obs_t ea, eb, oa, ob;
      logic [127:0] d0, d1;
      logic [7:0]   c;
      d0 = rnd128();
      d1 = rnd128();
      for (int i = 0; i <= 301; i++) begin
         if (i == 0) begin
            drive(1, 0, 1, 32'h3020, d0, 2'd3);
            qa.push_back(mk(1, 32'h3020, d0, 2'd2, 0));
            qb.push_back(mk(1, 32'h3020, d0, 2'd3, 0));
         end else if (i <= 300) begin
            drive(0, 0, 1'($urandom), $urandom, rnd128(), 2'($urandom));
            c = (i > 255) ? 8'd255 : 8'(i);
            qa.push_back(mk(1, 32'h3020, d0, 2'd2, c));
            qb.push_back(mk(1, 32'h3020, d0, 2'd3, c));
         end else begin
            drive(1, 0, 1, 32'h3030, d1, 2'd0);
            qa.push_back(mk(1, 32'h3030, d1, 2'd0, 0));
            qb.push_back(mk(1, 32'h3030, d1, 2'd0, 0));
         end
         tick();
         ea = qa.pop_front(); eb = qb.pop_front(); oa = obs_a(); ob = obs_b();
         total += 2;
         if (oa !== ea) $display("FAIL stall[%0d] A got %s exp %s", i, fmt(oa), fmt(ea));
         else passed++;
         if (ob !== eb) $display("FAIL stall[%0d] B got %s exp %s", i, fmt(ob), fmt(eb));
         else passed++;
      end
   endtask

   task automatic test_flush();
      obs_t ea, eb, oa, ob;
      logic [127:0] d0, d1;
      d0 = rnd128();
      d1 = rnd128();
      for (int s = 0; s < 7; s++) begin
         case (s)
            0: begin
               drive(1, 0, 1, 32'h3050, d0, 2'd2);
               qa.push_back(mk(1, 32'h3050, d0, 2'd1, 0));
               qb.push_back(mk(1, 32'h3050, d0, 2'd2, 0));
            end
            1, 2: begin
               drive(0, 0, 1, 32'h3054, d1, 2'd1);
               qa.push_back(mk(1, 32'h3050, d0, 2'd1, 8'(s)));
               qb.push_back(mk(1, 32'h3050, d0, 2'd2, 8'(s)));
            end
            3: begin
               drive(0, 1, 1, 32'h3010, d1, 2'd3);
               qa.push_back(mk(0, 32'h3010, '0, 0, 0));
               qb.push_back(mk(0, 32'h0, '0, 0, 0));
            end
            4: begin
               drive(0, 0, 1, 32'h3058, d1, 2'd3);
               qa.push_back(mk(0, 32'h3010, '0, 0, 0));
               qb.push_back(mk(0, 32'h0, '0, 0, 0));
            end
            5: begin
               drive(1, 0, 1, 32'h3060, d1, 2'd1);
               qa.push_back(mk(1, 32'h3060, d1, 2'd0, 0));
               qb.push_back(mk(1, 32'h3060, d1, 2'd1, 0));
            end
            default: begin
               drive(1, 1, 1, 32'h3070, d0, 2'd2);
               qa.push_back(mk(0, 32'h3070, '0, 0, 0));
               qb.push_back(mk(0, 32'h0, '0, 0, 0));
            end
         endcase
         tick();
         ea = qa.pop_front(); eb = qb.pop_front(); oa = obs_a(); ob = obs_b();
         total += 2;
         if (oa !== ea) $display("FAIL flush[%0d] A got %s exp %s", s, fmt(oa), fmt(ea));
         else passed++;
         if (ob !== eb) $display("FAIL flush[%0d] B got %s exp %s", s, fmt(ob), fmt(eb));
         else passed++;
      end
   endtask

   // Loading an empty slot zeroes payload and Tnew but tracks the PC; a
   // stall on that bubble does not count.
   task automatic test_bubble();
      obs_t ea, eb, oa, ob;
      logic [127:0] d0;
      d0 = rnd128();
      for (int s = 0; s < 5; s++) begin
         if (s == 0) begin
            drive(1, 0, 1, 32'h3080, d0, 2'd2);
            qa.push_back(mk(1, 32'h3080, d0, 2'd1, 0));
            qb.push_back(mk(1, 32'h3080, d0, 2'd2, 0));
         end else if (s == 1) begin
            drive(1, 0, 0, 32'h3090, A5, 2'd3);
            qa.push_back(mk(0, 32'h3090, '0, 0, 0));
            qb.push_back(mk(0, 32'h3090, '0, 0, 0));
         end else begin
            drive(0, 0, 1, 32'h30F0, d0, 2'd3);
            qa.push_back(mk(0, 32'h3090, '0, 0, 0));
            qb.push_back(mk(0, 32'h3090, '0, 0, 0));
         end
         tick();
         ea = qa.pop_front(); eb = qb.pop_front(); oa = obs_a(); ob = obs_b();
         total += 2;
         if (oa !== ea) $display("FAIL bubble[%0d] A got %s exp %s", s, fmt(oa), fmt(ea));
         else passed++;
         if (ob !== eb) $display("FAIL bubble[%0d] B got %s exp %s", s, fmt(ob), fmt(eb));
         else passed++;
      end
   endtask

   task automatic test_reset_midstall();
      obs_t ea, eb, oa, ob;
      logic [127:0] d0;
      d0 = rnd128();
      for (int s = 0; s < 8; s++) begin
         if (s == 0) begin
            drive(1, 0, 1, 32'h30A0, d0, 2'd2);
            qa.push_back(mk(1, 32'h30A0, d0, 2'd1, 0));
            qb.push_back(mk(1, 32'h30A0, d0, 2'd2, 0));
            tick();
         end else if (s <= 5) begin
            drive(0, 0, 1, 32'h30A4, A5, 2'd1);
            qa.push_back(mk(1, 32'h30A0, d0, 2'd1, 8'(s)));
            qb.push_back(mk(1, 32'h30A0, d0, 2'd2, 8'(s)));
            tick();
         end else if (s == 6) begin
            #3 reset = 1'b1;
            qa.push_back(mk(0, RPC, '0, 0, 0));
            qb.push_back(mk(0, RPC, '0, 0, 0));
            #1;
         end else begin
            reset = 1'b0;
            qa.push_back(mk(0, RPC, '0, 0, 0));
            qb.push_back(mk(0, RPC, '0, 0, 0));
            tick();
         end
         ea = qa.pop_front(); eb = qb.pop_front(); oa = obs_a(); ob = obs_b();
         total += 2;
         if (oa !== ea) $display("FAIL rst_stall[%0d] A got %s exp %s", s, fmt(oa), fmt(ea));
         else passed++;
         if (ob !== eb) $display("FAIL rst_stall[%0d] B got %s exp %s", s, fmt(ob), fmt(eb));
         else passed++;
      end
   endtask

   // Random mix of load/hold/flush every cycle against a behavioural model;
   // the first step is a forced flush so the model starts from a known state.
   task automatic test_back_to_back();
      obs_t ea, eb, oa, ob, ma, mb;
      logic e, f, v;
      logic [31:0]  p;
      logic [127:0] d;
      logic [1:0]   t;
      ma = '0;
      mb = '0;
      for (int i = 0; i < 80; i++) begin
         e = ($urandom_range(0, 3) != 0);
         f = (i == 0) || ($urandom_range(0, 7) == 0);
         v = ($urandom_range(0, 4) != 0);
         p = $urandom;
         d = rnd128();
         t = 2'($urandom);
         drive(e, f, v, p, d, t);
         if (f) begin
            ma = mk(0, p, '0, 0, 0);
            mb = mk(0, 32'h0, '0, 0, 0);
         end else if (!e) begin
            if (ma.v && ma.c != 8'hFF) ma.c = ma.c + 8'd1;
            if (mb.v && mb.c != 8'hFF) mb.c = mb.c + 8'd1;
         end else if (v) begin
            ma = mk(1, p, d, dec2(t), 0);
            mb = mk(1, p, d, t, 0);
         end else begin
            ma = mk(0, p, '0, 0, 0);
            mb = mk(0, p, '0, 0, 0);
         end
         qa.push_back(ma);
         qb.push_back(mb);
         tick();
         ea = qa.pop_front(); eb = qb.pop_front(); oa = obs_a(); ob = obs_b();
         total += 2;
         if (oa !== ea) $display("FAIL b2b[%0d] A got %s exp %s", i, fmt(oa), fmt(ea));
         else passed++;
         if (ob !== eb) $display("FAIL b2b[%0d] B got %s exp %s", i, fmt(ob), fmt(eb));
         else passed++;
      end
   endtask

   initial begin
      reset = 1'b1;
      drive(0, 0, 0, 32'h0, '0, 2'd0);
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_load();
      test_stall();
      test_flush();
      test_bubble();
      test_reset_midstall();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, passed=%0d total=%0d", passed, total);
      $fatal(1, "timeout");
   end

endmodule
